// File: rtl/note_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | note_sequencer_if: control, note-table write and voice-output bundle.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface note_sequencer_if #(
    parameter int FREQ_BITS       = 16,
    parameter int PULSEWIDTH_BITS = 12,
    parameter int ADDR_BITS       = 4,
    parameter int DUR_BITS        = 8
) ();
    logic                                         start;
    logic                                         stop;
    logic                                         loop_en;
    logic [15:0]                                  tick_div;
    logic                                         wr_en;
    logic [ADDR_BITS-1:0]                         wr_addr;
    logic [FREQ_BITS+PULSEWIDTH_BITS+3+DUR_BITS-1:0] wr_data;
    logic [FREQ_BITS-1:0]                         tone_freq;
    logic [PULSEWIDTH_BITS-1:0]                   pulse_width;
    logic                                         en_noise;
    logic                                         en_pulse;
    logic                                         en_triangle;
    logic                                         test;
    logic                                         busy;
    logic [ADDR_BITS-1:0]                         note_index;
    logic                                         done;

    modport master (
        output start, stop, loop_en, tick_div, wr_en, wr_addr, wr_data,
        input  tone_freq, pulse_width, en_noise, en_pulse, en_triangle,
               test, busy, note_index, done
    );

    modport slave (
        input  start, stop, loop_en, tick_div, wr_en, wr_addr, wr_data,
        output tone_freq, pulse_width, en_noise, en_pulse, en_triangle,
               test, busy, note_index, done
    );
endinterface
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | note_sequencer: steps through a note table, driving tone/pulse/enable       |
// | settings to a voice for duration*(tick_div+1) cycles per entry.             |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module note_sequencer #(
    parameter int FREQ_BITS       = 16,
    parameter int PULSEWIDTH_BITS = 12,
    parameter int ADDR_BITS       = 4,
    parameter int DUR_BITS        = 8
) (
    input  wire logic        main_clk,
    input  wire logic        reset,
    note_sequencer_if.slave  bus
);
    localparam int c_ENTRY_W = FREQ_BITS + PULSEWIDTH_BITS + 3 + DUR_BITS;
    localparam int c_DEPTH   = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] c_LAST_IDX = '1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_PLAY = 2'd2;

    logic [c_ENTRY_W-1:0]       r_table [0:c_DEPTH-1];
    logic [1:0]                 r_state;
    logic [ADDR_BITS-1:0]       r_note_index;
    logic [15:0]                r_presc;
    logic [DUR_BITS-1:0]        r_tick_cnt;
    logic [DUR_BITS-1:0]        r_dur;
    logic [FREQ_BITS-1:0]       r_tone_freq;
    logic [PULSEWIDTH_BITS-1:0] r_pulse_width;
    logic                       r_en_noise;
    logic                       r_en_pulse;
    logic                       r_en_triangle;
    logic                       r_test;
    logic                       r_busy;
    logic                       r_done;

    logic [c_ENTRY_W-1:0]       w_entry;
    logic [DUR_BITS-1:0]        w_dur;
    logic [FREQ_BITS-1:0]       w_freq;
    logic [PULSEWIDTH_BITS-1:0] w_pw;
    logic                       w_tick;
    logic                       w_note_end;

    // Table is written with non-blocking semantics, so a same-cycle read in LOAD sees old data.
    always_ff @(posedge main_clk) begin
        if (bus.wr_en) begin
            r_table[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign w_entry    = r_table[r_note_index];
    assign w_dur      = w_entry[DUR_BITS-1:0];
    assign w_pw       = w_entry[DUR_BITS+3 +: PULSEWIDTH_BITS];
    assign w_freq     = w_entry[DUR_BITS+3+PULSEWIDTH_BITS +: FREQ_BITS];
    // >= keeps the prescaler from running past a tick_div that was lowered mid-note.
    assign w_tick     = (r_presc >= bus.tick_div);
    assign w_note_end = w_tick && (r_tick_cnt >= r_dur - DUR_BITS'(1));

    always_ff @(posedge main_clk) begin
        if (!reset) begin
            r_state       <= c_IDLE;
            r_note_index  <= '0;
            r_presc       <= '0;
            r_tick_cnt    <= '0;
            r_dur         <= '0;
            r_tone_freq   <= '0;
            r_pulse_width <= '0;
            r_en_noise    <= 1'b0;
            r_en_pulse    <= 1'b0;
            r_en_triangle <= 1'b0;
            r_test        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.stop) begin
                r_state       <= c_IDLE;
                r_busy        <= 1'b0;
                r_en_noise    <= 1'b0;
                r_en_pulse    <= 1'b0;
                r_en_triangle <= 1'b0;
                r_test        <= 1'b0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        r_test <= 1'b0;
                        if (bus.start) begin
                            r_state      <= c_LOAD;
                            r_busy       <= 1'b1;
                            r_note_index <= '0;
                        end
                    end
                    c_LOAD: begin
                        r_presc       <= '0;
                        r_tick_cnt    <= '0;
                        r_test        <= 1'b0;
                        r_en_noise    <= 1'b0;
                        r_en_pulse    <= 1'b0;
                        r_en_triangle <= 1'b0;
                        if (w_dur != '0) begin
                            r_state       <= c_PLAY;
                            r_dur         <= w_dur;
                            r_tone_freq   <= w_freq;
                            r_pulse_width <= w_pw;
                            r_en_noise    <= w_entry[DUR_BITS+2];
                            r_en_pulse    <= w_entry[DUR_BITS+1];
                            r_en_triangle <= w_entry[DUR_BITS];
                            r_test        <= 1'b1;
                        end else if (r_note_index != '0 && bus.loop_en) begin
                            r_note_index <= '0;
                        end else begin
                            r_state <= c_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    c_PLAY: begin
                        r_test <= 1'b0;
                        if (w_tick) begin
                            r_presc    <= '0;
                            r_tick_cnt <= r_tick_cnt + DUR_BITS'(1);
                        end else begin
                            r_presc <= r_presc + 16'd1;
                        end
                        if (w_note_end) begin
                            r_en_noise    <= 1'b0;
                            r_en_pulse    <= 1'b0;
                            r_en_triangle <= 1'b0;
                            if (r_note_index != c_LAST_IDX) begin
                                r_note_index <= r_note_index + ADDR_BITS'(1);
                                r_state      <= c_LOAD;
                            end else if (bus.loop_en) begin
                                r_note_index <= '0;
                                r_state      <= c_LOAD;
                            end else begin
                                r_state <= c_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.tone_freq   = r_tone_freq;
    assign bus.pulse_width = r_pulse_width;
    assign bus.en_noise    = r_en_noise;
    assign bus.en_pulse    = r_en_pulse;
    assign bus.en_triangle = r_en_triangle;
    assign bus.test        = r_test;
    assign bus.busy        = r_busy;
    assign bus.note_index  = r_note_index;
    assign bus.done        = r_done;
endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_note_sequencer: directed scenarios with a note-start/done scoreboard.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_note_sequencer;
    typedef struct packed {
        logic        is_done;
        logic [3:0]  idx;
        logic [15:0] freq;
        logic [11:0] pw;
        logic [2:0]  en;
        logic [31:0] cyc;
    } ev_t;

    logic main_clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_err;
    int   t;
    ev_t  q[$];
    ev_t  e;

    note_sequencer_if #(.FREQ_BITS(16), .PULSEWIDTH_BITS(12), .ADDR_BITS(4), .DUR_BITS(8)) bus ();

    note_sequencer #(.FREQ_BITS(16), .PULSEWIDTH_BITS(12), .ADDR_BITS(4), .DUR_BITS(8)) dut (
        .main_clk (main_clk),
        .reset    (reset),
        .bus      (bus)
    );

    initial begin
        main_clk = 1'b0;
        forever #5 main_clk = ~main_clk;
    end

    always @(posedge main_clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Monitor: every note start (test pulse) or done pulse must match the queue head.
    always @(negedge main_clk) begin
        if (bus.test || bus.done) begin
            n_checks++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: test=%0b done=%0b idx=%0d freq=%h at cycle %0d, nothing expected",
                         bus.test, bus.done, bus.note_index, bus.tone_freq, cyc);
            end else begin
                e = q.pop_front();
                if (bus.done !== e.is_done || 32'(cyc) != e.cyc ||
                    (!e.is_done && (bus.note_index !== e.idx || bus.tone_freq !== e.freq ||
                     bus.pulse_width !== e.pw ||
                     {bus.en_noise, bus.en_pulse, bus.en_triangle} !== e.en))) begin
                    n_err++;
                    $display("FAIL event: got done=%0b idx=%0d freq=%h pw=%h en=%b cyc=%0d, expected done=%0b idx=%0d freq=%h pw=%h en=%b cyc=%0d",
                             bus.done, bus.note_index, bus.tone_freq, bus.pulse_width,
                             {bus.en_noise, bus.en_pulse, bus.en_triangle}, cyc,
                             e.is_done, e.idx, e.freq, e.pw, e.en, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_play(input int idx, input logic [15:0] freq, input logic [11:0] pw,
                             input logic [2:0] en, input int c);
        q.push_back('{is_done: 1'b0, idx: 4'(idx), freq: freq, pw: pw, en: en, cyc: 32'(c)});
    endtask

    task automatic push_done(input int c);
        q.push_back('{is_done: 1'b1, idx: 4'd0, freq: 16'd0, pw: 12'd0, en: 3'd0, cyc: 32'(c)});
    endtask

    task automatic write_entry(input int addr, input logic [15:0] freq, input logic [11:0] pw,
                               input logic [2:0] en, input logic [7:0] dur);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'(addr);
        bus.wr_data = {freq, pw, en, dur};
        @(negedge main_clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge main_clk);
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        @(negedge main_clk);
        bus.stop = 1'b0;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_busy"}, 32'(bus.busy), 0);
        chk({name, "_en"}, 32'({bus.en_noise, bus.en_pulse, bus.en_triangle}), 0);
        chk({name, "_done"}, 32'(bus.done), 0);
        chk({name, "_test"}, 32'(bus.test), 0);
    endtask

    initial begin
        cyc = 0; n_checks = 0; n_err = 0;
        reset = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0; bus.tick_div = 16'd0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        repeat (3) @(negedge main_clk);
        chk_idle("reset");
        chk("reset_freq", 32'(bus.tone_freq), 0);
        chk("reset_pw", 32'(bus.pulse_width), 0);
        chk("reset_idx", 32'(bus.note_index), 0);
        reset = 1'b1;
        @(negedge main_clk);

        // Single note of 3 ticks at tick_div=1, then terminator ends the run.
        write_entry(0, 16'h1000, 12'h800, 3'b101, 8'd3);
        write_entry(1, 16'h0000, 12'h000, 3'b000, 8'd0);
        bus.tick_div = 16'd1;
        bus.loop_en  = 1'b0;
        t = cyc;
        push_play(0, 16'h1000, 12'h800, 3'b101, t + 2);
        push_done(t + 9);
        pulse_start();
        chk("load_busy", 32'(bus.busy), 1);
        chk("load_en", 32'({bus.en_noise, bus.en_pulse, bus.en_triangle}), 0);
        repeat (2) @(negedge main_clk);
        chk("test_one_cycle", 32'(bus.test), 0);
        repeat (4) @(negedge main_clk);
        chk("play_last_freq", 32'(bus.tone_freq), 32'h1000);
        chk("play_last_busy", 32'(bus.busy), 1);
        repeat (3) @(negedge main_clk);
        chk_idle("after_done");
        chk("idle_freq_hold", 32'(bus.tone_freq), 32'h1000);
        chk("idle_pw_hold", 32'(bus.pulse_width), 32'h800);

        // All 16 entries of one tick, tick_div=0, looping past the last entry.
        for (int i = 0; i < 16; i++)
            write_entry(i, 16'((i + 1) * 256), 12'(i), 3'(i + 1), 8'd1);
        bus.tick_div = 16'd0;
        bus.loop_en  = 1'b1;
        t = cyc;
        for (int k = 0; k < 20; k++)
            push_play(k % 16, 16'(((k % 16) + 1) * 256), 12'(k % 16), 3'((k % 16) + 1), t + 2 + 2 * k);
        pulse_start();
        repeat (40) @(negedge main_clk);
        pulse_stop();
        chk_idle("loop_stop");

        // Stop during entry 2, then start+stop together must stay idle.
        bus.tick_div = 16'd3;
        bus.loop_en  = 1'b0;
        t = cyc;
        push_play(0, 16'h0100, 12'h000, 3'b001, t + 2);
        push_play(1, 16'h0200, 12'h001, 3'b010, t + 7);
        push_play(2, 16'h0300, 12'h002, 3'b011, t + 12);
        pulse_start();
        repeat (12) @(negedge main_clk);
        chk("entry2_en", 32'({bus.en_noise, bus.en_pulse, bus.en_triangle}), 32'b011);
        pulse_stop();
        chk_idle("stop_play");
        bus.start = 1'b1;
        pulse_stop();
        bus.start = 1'b0;
        chk("start_stop_busy", 32'(bus.busy), 0);
        repeat (3) @(negedge main_clk);
        chk("start_stop_busy_later", 32'(bus.busy), 0);

        // Reset during entry 1, then replay from entry 0 with the table intact.
        t = cyc;
        push_play(0, 16'h0100, 12'h000, 3'b001, t + 2);
        push_play(1, 16'h0200, 12'h001, 3'b010, t + 7);
        pulse_start();
        repeat (7) @(negedge main_clk);
        reset = 1'b0;
        @(negedge main_clk);
        chk_idle("mid_reset");
        chk("mid_reset_freq", 32'(bus.tone_freq), 0);
        chk("mid_reset_pw", 32'(bus.pulse_width), 0);
        chk("mid_reset_idx", 32'(bus.note_index), 0);
        reset = 1'b1;
        @(negedge main_clk);
        t = cyc;
        push_play(0, 16'h0100, 12'h000, 3'b001, t + 2);
        push_play(1, 16'h0200, 12'h001, 3'b010, t + 7);
        pulse_start();
        repeat (7) @(negedge main_clk);
        pulse_stop();
        chk("replay_stop_busy", 32'(bus.busy), 0);

        // Rewrite entry 0 while it plays; the loop's second pass picks up the new data.
        bus.tick_div = 16'd1;
        bus.loop_en  = 1'b1;
        write_entry(0, 16'h1000, 12'h800, 3'b101, 8'd3);
        write_entry(1, 16'h3333, 12'h111, 3'b010, 8'd1);
        write_entry(2, 16'h0000, 12'h000, 3'b000, 8'd0);
        t = cyc;
        push_play(0, 16'h1000, 12'h800, 3'b101, t + 2);
        push_play(1, 16'h3333, 12'h111, 3'b010, t + 9);
        push_play(0, 16'h2222, 12'h222, 3'b110, t + 13);
        pulse_start();
        repeat (2) @(negedge main_clk);
        write_entry(0, 16'h2222, 12'h222, 3'b110, 8'd3);
        repeat (3) @(negedge main_clk);
        chk("rewrite_freq_held", 32'(bus.tone_freq), 32'h1000);
        chk("rewrite_en_held", 32'({bus.en_noise, bus.en_pulse, bus.en_triangle}), 32'b101);
        repeat (7) @(negedge main_clk);
        pulse_stop();
        chk("rewrite_stop_busy", 32'(bus.busy), 0);

        repeat (2) @(negedge main_clk);
        chk("scoreboard_drained", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameters: FREQ_BITS, default 16, tone word width; PULSEWIDTH_BITS, default 12, pulse width; ADDR_BITS, default 4, note table address (16 entries); DUR_BITS, default 8, note duration in ticks.
REQ-002 SHALL have ports (name, direction, width, meaning):
- main_clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  begin playback at entry 0.
- stop  in  1  abort playback.
- loop_en  in  1  restart at entry 0 after last entry or terminator.
- tick_div  in  16  tempo prescaler; tick period = tick_div+1 cycles.
- wr_en  in  1  note table write strobe.
- wr_addr  in  ADDR_BITS  write address.
- wr_data  in  FREQ_BITS+PULSEWIDTH_BITS+3+DUR_BITS  packed entry, MSB first: {freq, pulse_width, en_noise, en_pulse, en_triangle, duration}.
- tone_freq  out  FREQ_BITS  tone word to voice.
- pulse_width  out  PULSEWIDTH_BITS  pulse width to voice.
- en_noise, en_pulse, en_triangle  out  1 each  waveform enables to voice.
- test  out  1  one-cycle accumulator retrigger to voice.
- busy  out  1  high when not IDLE.
- note_index  out  ADDR_BITS  current entry.
- done  out  1  one-cycle end-of-sequence pulse.

Function
REQ-003 SHALL hold a 2**ADDR_BITS entry note table written when wr_en=1; table is not reset.
REQ-004 SHALL implement states IDLE, LOAD, PLAY; all outputs registered.
REQ-005 IDLE: start=1 and stop=0 -> LOAD with note_index=0 next cycle; otherwise stay.
REQ-006 LOAD (exactly one cycle): read entry[note_index]; enables and test forced 0; prescaler and tick counter cleared.
REQ-007 LOAD, duration!=0 -> PLAY; tone_freq, pulse_width, enables take entry values at PLAY entry; test=1 in first PLAY cycle only.
REQ-008 LOAD, duration==0 (terminator): if note_index!=0 and loop_en=1 -> LOAD, note_index=0; else -> IDLE with done=1 for one cycle.
REQ-009 PLAY: prescaler increments each cycle; when prescaler==tick_div, a tick occurs and prescaler returns to 0; tick_div=0 -> tick every cycle.
REQ-010 PLAY: tick counter increments per tick; on the tick where counter==duration-1, note ends; PLAY lasts exactly duration*(tick_div+1) cycles.
REQ-011 Note end, note_index<max: note_index+1, -> LOAD.
REQ-012 Note end, note_index==2**ADDR_BITS-1: loop_en=1 -> note_index=0, LOAD; else -> IDLE, done=1 one cycle.
REQ-013 In IDLE: enables=0, test=0; tone_freq and pulse_width hold last values.
REQ-014 stop=1 in any state -> IDLE next cycle, enables=0, test=0, done=0; stop wins over simultaneous start.
REQ-015 start while busy=1 SHALL be ignored.
REQ-016 Write during LOAD to the entry being read SHALL return old data; writes during PLAY SHALL not alter the playing note's outputs.
REQ-017 tick_div and loop_en SHALL be sampled live each cycle; tick_div change mid-note takes effect at the next prescaler compare.
REQ-018 Counters SHALL never wrap silently: prescaler 16 bits, tick counter DUR_BITS bits.

Reset
REQ-019 reset=0 at a rising edge SHALL force: state IDLE, note_index=0, tone_freq=0, pulse_width=0, all enables 0, test=0, done=0, busy=0, prescaler and tick counter 0; applies mid-playback.
REQ-020 Table contents SHALL be unaffected by reset.

Verification
REQ-021 Entry0 {freq 0x1000, dur 3}, entry1 dur 0, tick_div=1, loop_en=0, start at cycle T -> LOAD T+1; PLAY T+2..T+7 with tone_freq=0x1000, test=1 at T+2 only; LOAD T+8; IDLE at T+9 with done=1 that cycle only.
REQ-022 All 16 entries dur 1, tick_div=0, loop_en=1 -> note_index 0..15 then 0, each PLAY 1 cycle separated by 1 LOAD cycle; done never asserted.
REQ-023 stop asserted during PLAY of entry 2 -> IDLE next cycle, enables 0, busy 0, done 0; start with stop in same cycle -> stays IDLE.
REQ-024 reset=0 mid-PLAY -> all outputs reset values next edge; following start replays from entry 0 with unchanged table.
REQ-025 Rewrite entry0 freq to 0x2222 during its PLAY -> tone_freq stays 0x1000 to note end; next loop iteration plays 0x2222.
